treedemux16: RTL and testbench
==============================

TREEDEMUX16 -- requirements
Module: treedemux16

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 72, giving the data beat width in bits.
REQ-002 The block SHALL provide parameter N, default 16, giving the number of output ports; legal range 5..16.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in  input  WIDTH  input beat.
REQ-006 The block SHALL have port valid_in  input  1  data_in/dest_in qualifier.
REQ-007 The block SHALL have port dest_in  input  4  destination output index.
REQ-008 The block SHALL have port data_out  output  WIDTH x [N-1:0]  unpacked array of output beats.
REQ-009 The block SHALL have port valid_out  output  N  per-output qualifier, at most one bit set.
REQ-010 The block SHALL have port drop_pulse  output  1  one-cycle flag for an out-of-range beat.
REQ-011 The block SHALL have port drop_cnt  output  16  count of out-of-range beats.

Function
REQ-012 Routing SHALL be a two-level registered tree: level 0 decodes dest_in[3:2] to group g; level 1 decodes dest_in[1:0] within group g.
REQ-013 Groups SHALL number N/4 full groups plus one residual group of N%4 outputs when N%4 != 0.
REQ-014 Latency SHALL be exactly 2 cycles: a beat with valid_in=1 at edge k appears with valid_out[dest_in]=1 at edge k+2.
REQ-015 Throughput SHALL be one beat per cycle with no backpressure; back-to-back beats to the same or different destinations SHALL all be delivered in order.
REQ-016 valid_out SHALL be 0 or one-hot every cycle.
REQ-017 A data_out[i] register SHALL load only when its valid_out[i] is being set; otherwise it SHALL hold its previous value.
REQ-018 A beat with dest_in >= N SHALL be discarded at level 0: no valid_out bit is set and no data_out register changes.
REQ-019 A discarded beat SHALL pulse drop_pulse high for one cycle, 1 cycle after acceptance.
REQ-020 drop_cnt SHALL increment by 1 per discarded beat and saturate at 16'hFFFF.
REQ-021 valid_in=0 SHALL insert a bubble that propagates as all-zero valid_out 2 cycles later.

Reset
REQ-022 While RST_N=0, valid_out, all internal valid stages, drop_pulse and drop_cnt SHALL be 0, and data_out registers SHALL be 0, asynchronously.
REQ-023 In-flight beats at reset assertion SHALL be lost; the first beat accepted after deassertion SHALL follow REQ-014.

Configuration
REQ-024 Macro TREEDEMUX_DROP_CNT_EN SHALL compile in drop detection logic (REQ-019, REQ-020).
REQ-025 Without TREEDEMUX_DROP_CNT_EN, out-of-range beats SHALL still be discarded silently, drop_pulse and drop_cnt SHALL remain ports tied to 0, and no counter flops SHALL exist.

Structure
REQ-026 Shared package treemux_pkg SHALL hold TREE_GROUP=4, DEST_W=4, DROP_CNT_W=16 and the MAX_N=16 constant.
REQ-027 Sub-module treedemux_prim (parameters WIDTH, N<=4) SHALL implement one registered 1:N level; treedemux16 instantiates one at level 0 and N/4 full plus one residual instance at level 1.
REQ-028 Level 0 SHALL forward dest_in[1:0] alongside data to level 1.

Verification
REQ-029 N=16, beat 0xAA to dest 5 at cycle 0 -> valid_out=16'h0020, data_out[5]=0xAA at cycle 2; all other data_out unchanged.
REQ-030 N=16, dests 0,15,3,3 on consecutive cycles -> valid_out 0x0001, 0x8000, 0x0008, 0x0008 on cycles 2-5 with matching data.
REQ-031 N=10, dest 9 then dest 12 -> valid_out[9] at cycle 2; for dest 12, no valid_out, drop_pulse at cycle 2, drop_cnt=1.
REQ-032 With macro on, 65540 out-of-range beats -> drop_cnt=16'hFFFF; without macro -> drop_cnt=0 and drop_pulse=0 throughout.
REQ-033 Beat to dest 7 accepted, RST_N low 1 cycle later -> valid_out[7] never asserts, all outputs 0 during reset; beat to dest 2 after release arrives 2 cycles later.
REQ-034 valid_in pattern 1,0,1 to dest 4 -> valid_out[4] pattern 1,0,1 on cycles 2-4, data_out[4] holds during bubble.

Source files
------------

// File: rtl/treemux_pkg.sv
// Shared constants and helpers for the two-level registered demux tree.
// Imported by treedemux_prim and treedemux16.
package treemux_pkg;

  localparam int TREE_GROUP = 4;
  localparam int DEST_W     = 4;
  localparam int DROP_CNT_W = 16;
  localparam int MAX_N      = 16;

  // Number of level-1 groups: full groups of TREE_GROUP plus a residual one.
  function automatic int num_groups(input int n);
    return (n + TREE_GROUP - 1) / TREE_GROUP;
  endfunction

  // Outputs served by level-1 group g of an n-output tree.
  function automatic int group_size(input int n, input int g);
    return (g < n / TREE_GROUP) ? TREE_GROUP : n % TREE_GROUP;
  endfunction

endpackage : treemux_pkg

// File: rtl/treedemux_prim.sv
// One registered 1:N demux level (N <= 4). An output register loads only
// when its valid is being set; otherwise it holds.
module treedemux_prim
  import treemux_pkg::*;
#(
  parameter int WIDTH = 72,
  parameter int N     = TREE_GROUP
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic [1:0]       sel_in,
  output logic [WIDTH-1:0] data_out [N-1:0],
  output logic [N-1:0]     valid_out
);

  logic [N-1:0]     valid_d, valid_q;
  logic [WIDTH-1:0] data_d [N-1:0];
  logic [WIDTH-1:0] data_q [N-1:0];

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    valid_d = '0;
    for (int i = 0; i < N; i++) begin
      data_d[i]  = data_q[i];
      valid_d[i] = valid_in && (sel_in == 2'(i));
      if (valid_d[i]) data_d[i] = data_in;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      // NOTE: data registers are reset too; outputs must read 0 while RST_N is low.
      for (int i = 0; i < N; i++) data_q[i] <= '0;
    end else begin
      // NOTE: <= so every flop samples pre-edge values regardless of statement order.
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) data_q[i] <= data_d[i];
    end
  end

  assign valid_out = valid_q;
  always_comb begin
    for (int i = 0; i < N; i++) data_out[i] = data_q[i];
  end

endmodule : treedemux_prim

// File: rtl/treedemux16.sv
// 1:N two-level registered demux tree, 2-cycle latency, no backpressure.
// Define TREEDEMUX_DROP_CNT_EN to build the out-of-range drop pulse/counter.
module treedemux16
  import treemux_pkg::*;
#(
  parameter int WIDTH = 72,
  parameter int N     = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  valid_in,
  input  logic [DEST_W-1:0]     dest_in,
  output logic [WIDTH-1:0]      data_out [N-1:0],
  output logic [N-1:0]          valid_out,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int N_GRP = num_groups(N);
  localparam int L0_W  = WIDTH + 2;

  logic             in_range;
  logic             l0_valid_in;
  logic [L0_W-1:0]  l0_payload;
  logic [L0_W-1:0]  l0_data [N_GRP-1:0];
  logic [N_GRP-1:0] l0_valid;

  // Out-of-range beats never enter the tree, so no output register moves.
  assign in_range    = {1'b0, dest_in} < 5'(N);
  assign l0_valid_in = valid_in && in_range;
  assign l0_payload  = {dest_in[1:0], data_in};

  treedemux_prim #(
    .WIDTH (L0_W),
    .N     (N_GRP)
  ) u_l0 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .data_in   (l0_payload),
    .valid_in  (l0_valid_in),
    .sel_in    (dest_in[3:2]),
    .data_out  (l0_data),
    .valid_out (l0_valid)
  );

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    localparam int GSZ = group_size(N, g);

    logic [WIDTH-1:0] grp_data [GSZ-1:0];
    logic [GSZ-1:0]   grp_valid;

    treedemux_prim #(
      .WIDTH (WIDTH),
      .N     (GSZ)
    ) u_l1 (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .data_in   (l0_data[g][WIDTH-1:0]),
      .valid_in  (l0_valid[g]),
      .sel_in    (l0_data[g][L0_W-1:WIDTH]),
      .data_out  (grp_data),
      .valid_out (grp_valid)
    );

    for (genvar j = 0; j < GSZ; j++) begin : g_out
      assign data_out[g*TREE_GROUP+j]  = grp_data[j];
      assign valid_out[g*TREE_GROUP+j] = grp_valid[j];
    end
  end

`ifdef TREEDEMUX_DROP_CNT_EN
  logic                  drop_now;
  logic                  drop_pulse_d, drop_pulse_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;

  assign drop_now = valid_in && !in_range;

  always_comb begin
    drop_pulse_d = drop_now;
    drop_cnt_d   = drop_cnt_q;
    if (drop_now && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;
`else
  assign drop_pulse = 1'b0;
  assign drop_cnt   = '0;
`endif

endmodule : treedemux16

// File: tb/tb_treedemux16.sv
// Self-checking bench: an N=16 and an N=10 tree share one stimulus stream
// and are compared against a beat-level reference model.
module tb_treedemux16;

`ifdef TREEDEMUX_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic [3:0]  dest_in = '0;

  logic [71:0] data16 [15:0];
  logic [15:0] valid16;
  logic        drop16;
  logic [15:0] cnt16;
  logic [71:0] data10 [9:0];
  logic [9:0]  valid10;
  logic        drop10;
  logic [15:0] cnt10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  treedemux16 #(.WIDTH(72), .N(16)) dut16 (
    .CLK(clk), .RST_N(rst_n), .data_in(data_in), .valid_in(valid_in),
    .dest_in(dest_in), .data_out(data16), .valid_out(valid16),
    .drop_pulse(drop16), .drop_cnt(cnt16)
  );

  treedemux16 #(.WIDTH(72), .N(10)) dut10 (
    .CLK(clk), .RST_N(rst_n), .data_in(data_in), .valid_in(valid_in),
    .dest_in(dest_in), .data_out(data10), .valid_out(valid10),
    .drop_pulse(drop10), .drop_cnt(cnt10)
  );

  // Reference model, index 0 = N16 instance, 1 = N10 instance.
  logic [71:0] exp_data [2][16];
  logic [15:0] exp_valid [2];
  logic        exp_drop [2];
  int          exp_cnt [2];
  logic        pend_v [2];
  int          pend_dest [2];
  logic [71:0] pend_data [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) exp_data[m][i] = '0;
      exp_valid[m] = '0;
      exp_drop[m]  = 1'b0;
      exp_cnt[m]   = 0;
      pend_v[m]    = 1'b0;
      pend_dest[m] = 0;
      pend_data[m] = '0;
    end
  endtask

  // A beat accepted at one edge shows on its output after the following edge.
  task automatic model_edge(input int m, input int n, input logic v,
                            input logic [3:0] d, input logic [71:0] x);
    exp_valid[m] = '0;
    if (pend_v[m]) begin
      exp_valid[m][pend_dest[m]] = 1'b1;
      exp_data[m][pend_dest[m]]  = pend_data[m];
    end
    pend_v[m]    = v && (int'(d) < n);
    pend_dest[m] = int'(d);
    pend_data[m] = x;
    exp_drop[m]  = DROP_EN && v && (int'(d) >= n);
    if (exp_drop[m] && exp_cnt[m] < 65535) exp_cnt[m]++;
  endtask

  // Called at a negedge; returns at the next negedge with outputs settled.
  task automatic tick(input logic v, input logic [3:0] d, input logic [71:0] x);
    valid_in = v;
    dest_in  = d;
    data_in  = x;
    @(posedge clk);
    model_edge(0, 16, v, d, x);
    model_edge(1, 10, v, d, x);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  function automatic logic [71:0] rand72();
    return 72'({$urandom, $urandom, $urandom});
  endfunction

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid16 !== 16'h0 || drop16 !== 1'b0 || cnt16 !== 16'h0) begin
      errors++;
      $display("FAIL reset16 valid=%h drop=%b cnt=%h required 0", valid16, drop16, cnt16);
    end
    checks++;
    if (valid10 !== 10'h0 || drop10 !== 1'b0 || cnt10 !== 16'h0) begin
      errors++;
      $display("FAIL reset10 valid=%h drop=%b cnt=%h required 0", valid10, drop10, cnt10);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data16[i] !== 72'h0) begin
        errors++;
        $display("FAIL reset_data16[%0d] got %h required 0", i, data16[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    tick(1'b1, 4'd5, 72'hAA);
    tick(1'b0, 4'd0, rand72());
    checks++;
    if (valid16 !== 16'h0020) begin
      errors++;
      $display("FAIL single_valid got %h required %h", valid16, 16'h0020);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data16[i] !== exp_data[0][i]) begin
        errors++;
        $display("FAIL single_data[%0d] got %h required %h", i, data16[i], exp_data[0][i]);
      end
    end
    checks++;
    if (data16[5] !== 72'hAA) begin
      errors++;
      $display("FAIL single_data5 got %h required aa", data16[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  dests [4];
    logic [71:0] vals [4];
    dests = '{4'd0, 4'd15, 4'd3, 4'd3};
    for (int k = 0; k < 4; k++) vals[k] = rand72();
    tick(1'b1, dests[0], vals[0]);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) tick(1'b1, dests[k+1], vals[k+1]);
      else       tick(1'b0, 4'd0, '0);
      checks++;
      if (valid16 !== (16'h1 << dests[k])) begin
        errors++;
        $display("FAIL b2b_valid[%0d] got %h required %h", k, valid16, 16'h1 << dests[k]);
      end
      checks++;
      if (data16[dests[k]] !== vals[k]) begin
        errors++;
        $display("FAIL b2b_data[%0d] got %h required %h", k, data16[dests[k]], vals[k]);
      end
    end
  endtask

  task automatic test_drop_n10();
    int cnt_before;
    cnt_before = exp_cnt[1];
    tick(1'b1, 4'd9, 72'h99);
    tick(1'b1, 4'd12, 72'h12);
    checks++;
    if (valid10 !== 10'h200) begin
      errors++;
      $display("FAIL drop_n10_valid9 got %h required 200", valid10);
    end
    checks++;
    if (drop10 !== DROP_EN) begin
      errors++;
      $display("FAIL drop_n10_pulse got %b required %b", drop10, DROP_EN);
    end
    checks++;
    if (cnt10 !== 16'(cnt_before + (DROP_EN ? 1 : 0))) begin
      errors++;
      $display("FAIL drop_n10_cnt got %0d required %0d", cnt10, cnt_before + (DROP_EN ? 1 : 0));
    end
    tick(1'b0, 4'd0, '0);
    checks++;
    if (valid10 !== 10'h0 || drop10 !== 1'b0) begin
      errors++;
      $display("FAIL drop_n10_after valid=%h drop=%b required 0", valid10, drop10);
    end
    checks++;
    if (data10[9] !== 72'h99) begin
      errors++;
      $display("FAIL drop_n10_data9 got %h required 99", data10[9]);
    end
  endtask

  task automatic test_bubble();
    logic        pat [3];
    logic [71:0] vals [3];
    logic [71:0] held;
    pat = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) vals[k] = rand72();
    tick(pat[0], 4'd4, vals[0]);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) tick(pat[k+1], 4'd4, vals[k+1]);
      else       tick(1'b0, 4'd0, '0);
      held = pat[k] ? vals[k] : vals[0];
      checks++;
      if (valid16 !== (pat[k] ? 16'h0010 : 16'h0)) begin
        errors++;
        $display("FAIL bubble_valid[%0d] got %h required %h", k, valid16, pat[k] ? 16'h0010 : 16'h0);
      end
      checks++;
      if (data16[4] !== held) begin
        errors++;
        $display("FAIL bubble_data4[%0d] got %h required %h", k, data16[4], held);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand72());
      checks++;
      if (valid16 !== exp_valid[0]) begin
        errors++;
        $display("FAIL rand_valid16 cyc %0d got %h required %h", k, valid16, exp_valid[0]);
      end
      checks++;
      if (valid10 !== exp_valid[1][9:0]) begin
        errors++;
        $display("FAIL rand_valid10 cyc %0d got %h required %h", k, valid10, exp_valid[1][9:0]);
      end
      checks++;
      if (drop10 !== exp_drop[1] || cnt10 !== 16'(exp_cnt[1])) begin
        errors++;
        $display("FAIL rand_drop10 cyc %0d got %b/%0d required %b/%0d", k, drop10, cnt10, exp_drop[1], exp_cnt[1]);
      end
      checks++;
      if (drop16 !== 1'b0 || cnt16 !== 16'h0) begin
        errors++;
        $display("FAIL rand_drop16 cyc %0d got %b/%0d required 0/0", k, drop16, cnt16);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (data16[i] !== exp_data[0][i]) begin
          errors++;
          $display("FAIL rand_data16[%0d] cyc %0d got %h required %h", i, k, data16[i], exp_data[0][i]);
        end
      end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (data10[i] !== exp_data[1][i]) begin
          errors++;
          $display("FAIL rand_data10[%0d] cyc %0d got %h required %h", i, k, data10[i], exp_data[1][i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [71:0] v2;
    tick(1'b1, 4'd7, rand72());
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (valid16 !== 16'h0 || cnt10 !== 16'h0 || data16[0] !== 72'h0 || data16[15] !== 72'h0) begin
      errors++;
      $display("FAIL inflight_async valid=%h cnt10=%0d d0=%h d15=%h required 0", valid16, cnt10, data16[0], data16[15]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid16 !== 16'h0 || valid10 !== 10'h0 || drop10 !== 1'b0) begin
      errors++;
      $display("FAIL inflight_hold valid16=%h valid10=%h drop=%b required 0", valid16, valid10, drop10);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (valid16 !== 16'h0) begin
      errors++;
      $display("FAIL inflight_lost valid16=%h required 0", valid16);
    end
    v2 = rand72();
    tick(1'b1, 4'd2, v2);
    tick(1'b0, 4'd0, '0);
    checks++;
    if (valid16 !== 16'h0004 || data16[2] !== v2) begin
      errors++;
      $display("FAIL inflight_after valid=%h data=%h required 0004/%h", valid16, data16[2], v2);
    end
    checks++;
    if (data16[7] !== 72'h0 || valid10 !== 10'h004) begin
      errors++;
      $display("FAIL inflight_d7 data7=%h valid10=%h required 0/004", data16[7], valid10);
    end
  endtask

  task automatic test_drop_saturate();
    for (int k = 0; k < 65540; k++) begin
      tick(1'b1, 4'd15, 72'(k));
      checks++;
      if (drop10 !== exp_drop[1] || cnt10 !== 16'(exp_cnt[1]) || valid10 !== 10'h0) begin
        errors++;
        $display("FAIL sat_drop10 cyc %0d got %b/%0d/%h required %b/%0d/0", k, drop10, cnt10, valid10, exp_drop[1], exp_cnt[1]);
      end
    end
    tick(1'b0, 4'd0, '0);
    checks++;
    if (cnt10 !== 16'(exp_cnt[1]) || drop10 !== 1'b0) begin
      errors++;
      $display("FAIL sat_final cnt=%h drop=%b required %h/0", cnt10, drop10, 16'(exp_cnt[1]));
    end
    checks++;
    if (valid16 !== 16'h8000 || data16[15] !== 72'(65539) || cnt16 !== 16'h0) begin
      errors++;
      $display("FAIL sat_n16 valid=%h data15=%h cnt=%0d required 8000/%h/0", valid16, data16[15], cnt16, 72'(65539));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_drop_n10();
    test_bubble();
    test_random();
    test_reset_inflight();
    test_drop_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_treedemux16
